// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TX_IDLE_LVL  = 1'b1;
  localparam logic TX_START_LVL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter. It counts 0..CLKS_PER_BIT-1 and
// wraps by itself. bit_end is high on the last cycle of each bit period.
// 'clear' holds the count at zero so the next bit period starts fresh.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16,
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          bit_end
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  assign bit_end = (count == LAST);

  // Free-running bit-period counter, held at zero while cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || bit_end) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter. It pulls one byte at a time from the
// upstream FIFO and sends each byte as an 8N1 frame.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit.
// Each frame then becomes 8E1.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W) + 1;

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  tx_state_t         state;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [CW-1:0]     baud_cnt;
  logic              bit_end;
  logic              baud_clear;
  logic              stop_near_end;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  // The baud counter only times START/DATA/PARITY/STOP. Holding it clear
  // through the handshake states makes START begin at count zero.
  assign baud_clear    = (state == IDLE) || (state == REQ) || (state == LOAD);
  assign stop_near_end = (state == STOP) && (baud_cnt == CW'(CLKS_PER_BIT - 2));
  assign shift_next    = shift_reg >> 1;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (baud_clear),
    .count  (baud_cnt),
    .bit_end(bit_end)
  );

  // Frame sequencer. All outputs are registered so tx never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tx        <= TX_IDLE_LVL;
      fifo_rd   <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      fifo_rd <= 1'b0;
      tx_done <= stop_near_end;
      case (state)
        IDLE: begin
          tx   <= TX_IDLE_LVL;
          busy <= 1'b0;
          if (en && !fifo_empty) begin
            state   <= REQ;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_reg <= fifo_data;
          bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^fifo_data;
`endif
          tx    <= TX_START_LVL;
          state <= START;
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == BW'(DATA_W - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= TX_IDLE_LVL;
`endif
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_next;
              tx        <= shift_next[0];
            end
          end
        end
        PARITY: begin
`ifdef UART_TX_PARITY_EN
          if (bit_end) begin
            state <= STOP;
            tx    <= TX_IDLE_LVL;
          end
`else
          state <= IDLE;
          tx    <= TX_IDLE_LVL;
          busy  <= 1'b0;
`endif
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            tx    <= TX_IDLE_LVL;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= TX_IDLE_LVL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Testbench for fifo_uart_tx with CLKS_PER_BIT=4.
// It includes a small 32-deep FIFO model with a registered data output.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_rd;
  logic          tx;
  logic          busy;
  logic          tx_done;

  logic [DW-1:0] mem [32];
  logic [5:0]    fcount  = '0;
  logic [4:0]    wptr    = '0;
  logic [4:0]    rptr    = '0;
  logic          wr_en   = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ok;
  int            rd_count = 0;

  int checks = 0;
  int passes = 0;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (fcount == 6'd0);
  assign rd_ok      = fifo_rd && (fcount != 6'd0);

  // FIFO model: its data output is valid in the cycle after a read strobe
  always @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= wr_data;
      wptr      <= wptr + 5'd1;
    end
    if (rd_ok) begin
      fifo_data <= mem[rptr];
      rptr      <= rptr + 5'd1;
    end
    fcount <= fcount + 6'(wr_en) - 6'(rd_ok);
  end

  // Counts the read strobes seen by the FIFO
  always @(posedge clk) begin
    if (fifo_rd) rd_count <= rd_count + 1;
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    else
      passes++;
  endtask

  // Caller is at a negedge; writes one byte during the following posedge
  task automatic push(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_tx_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Checks one whole frame cycle by cycle, starting at the first start-bit cycle
  task automatic check_frame(input logic [DW-1:0] b, input string tag);
    logic [10:0] bits;
    bit          ok;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = ^b;
`endif
    wait_tx_low(ok);
    check_output({tag, "_start_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      for (int c = 0; c < NBITS * CPB; c++) begin
        if (c > 0) @(negedge clk);
        check_output($sformatf("%s_tx_c%0d", tag, c), 32'(tx), 32'(bits[c / CPB]));
        check_output($sformatf("%s_done_c%0d", tag, c), 32'(tx_done),
                     32'(c == NBITS * CPB - 1));
      end
    end
  endtask

  task automatic measure_gap(output int gap);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx == 1'b0) break;
      gap++;
    end
  endtask

  // Stops the run if the bench stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  rd0;
    int  gap;
    bit  ok;
    bit  saw_rd;
    bit  saw_low;

    // Reset asserted before the first clock edge
    #2 rst = 1'b0;
    #1;
    check_output("rst0_tx", 32'(tx), 32'd1);
    check_output("rst0_rd", 32'(fifo_rd), 32'd0);
    check_output("rst0_busy", 32'(busy), 32'd0);
    check_output("rst0_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Test 1: reset between clock edges in the middle of a frame
    en = 1'b1;
    push(8'hA5);
    wait_tx_low(ok);
    check_output("t1_start_seen", 32'(ok), 32'd1);
    repeat (6) @(negedge clk);
    check_output("t1_busy_mid", 32'(busy), 32'd1);
    rd0 = rd_count;
    #2 rst = 1'b0;
    #1;
    check_output("t1_tx", 32'(tx), 32'd1);
    check_output("t1_rd", 32'(fifo_rd), 32'd0);
    check_output("t1_busy", 32'(busy), 32'd0);
    check_output("t1_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_output("t1_no_reread", 32'(rd_count - rd0), 32'd0);
    check_output("t1_idle_tx", 32'(tx), 32'd1);

    // Test 2: a single 0xA5 frame
    rd0 = rd_count;
    push(8'hA5);
    check_frame(8'hA5, "t2");
    @(negedge clk);
    check_output("t2_busy_after", 32'(busy), 32'd0);
    check_output("t2_tx_after", 32'(tx), 32'd1);
    check_output("t2_rd_pulses", 32'(rd_count - rd0), 32'd1);

    // Test 3: three frames sent back to back
    en  = 1'b0;
    rd0 = rd_count;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    en = 1'b1;
    check_frame(8'h00, "t3a");
    measure_gap(gap);
    check_output("t3_gap_ab", 32'(gap), 32'd3);
    check_frame(8'hFF, "t3b");
    measure_gap(gap);
    check_output("t3_gap_bc", 32'(gap), 32'd3);
    check_frame(8'h55, "t3c");
    @(negedge clk);
    check_output("t3_busy_after", 32'(busy), 32'd0);
    check_output("t3_fifo_empty", 32'(fifo_empty), 32'd1);
    check_output("t3_rd_pulses", 32'(rd_count - rd0), 32'd3);

    // Test 4: en held low while the FIFO has data
    en = 1'b0;
    push(8'h5A);
    saw_rd  = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fifo_rd) saw_rd = 1'b1;
      if (tx == 1'b0) saw_low = 1'b1;
    end
    check_output("t4_no_rd", 32'(saw_rd), 32'd0);
    check_output("t4_tx_idle", 32'(saw_low), 32'd0);
    en = 1'b1;
    @(negedge clk);
    check_output("t4_req_next", 32'(fifo_rd), 32'd1);
    check_frame(8'h5A, "t4");

    // Test 5: reset during data bit 3 of 0x3C, then the next byte is sent
    en = 1'b0;
    push(8'h3C);
    push(8'h81);
    en = 1'b1;
    wait_tx_low(ok);
    check_output("t5_start_seen", 32'(ok), 32'd1);
    repeat (4 + 3 * 4 + 1) @(negedge clk);
    check_output("t5_bit3_tx", 32'(tx), 32'd1);
    check_output("t5_busy_mid", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_output("t5_tx_rst", 32'(tx), 32'd1);
    check_output("t5_busy_rst", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check_frame(8'h81, "t5");

    // Test 6: payloads with even and odd parity
    en = 1'b0;
    push(8'hA5);
    push(8'h07);
    en = 1'b1;
    check_frame(8'hA5, "t6a");
    measure_gap(gap);
    check_output("t6_gap", 32'(gap), 32'd3);
    check_frame(8'h07, "t6b");
    @(negedge clk);
    check_output("t6_busy_after", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
